// File: rtl/rx_ts_queue.sv
// Receive-timestamp capture queue: pairs the RTC snapshot taken at SFD with parsed PTP header fields.
// Optional build macro RX_TSQ_EVENT_FILTER_EN keeps general messages (messageType[3]=1) out of the queue.
module rx_ts_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          rtc_clk,
  input  logic          rtc_rst,
  input  logic [79:0]   rtc_time_i,
  input  logic          rxts_trig_i,
  input  logic          rxts_valid_i,
  input  logic [79:0]   rx_sourcePortIdentity_i,
  input  logic [15:0]   rx_seqId_i,
  input  logic [3:0]    rx_messageType_i,
  input  logic [3:0]    rx_majorSdoId_i,
  input  logic          q_clr_i,
  input  logic          q_rd_i,
  output logic          q_valid_o,
  output logic [79:0]   q_ts_o,
  output logic [79:0]   q_srcPortId_o,
  output logic [15:0]   q_seqId_o,
  output logic [3:0]    q_msgType_o,
  output logic [3:0]    q_sdoId_o,
  output logic [AW:0]   q_level_o,
  output logic [7:0]    q_ovf_cnt_o,
  output logic [7:0]    q_orphan_cnt_o,
  output logic          int_rxts_o
);

  typedef struct packed {
    logic [79:0] ts;
    logic [79:0] src;
    logic [15:0] seq;
    logic [3:0]  msg_type;
    logic [3:0]  sdo_id;
  } rec_t;

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  rec_t        r_mem [DEPTH];
  logic [79:0] r_ts_latch;
  logic        r_ts_pending;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_ovf_cnt;
  logic [7:0]  r_orphan_cnt;

  logic        w_empty;
  logic        w_full;
  logic        w_keep;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic        w_ovf;
  logic        w_orphan;
  rec_t        w_rec;
  rec_t        w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

`ifdef RX_TSQ_EVENT_FILTER_EN
  // General messages still consume the pending time but never occupy a slot.
  assign w_keep = ~rx_messageType_i[3];
`else
  assign w_keep = 1'b1;
`endif

  // Flush wins over everything: a valid arriving with q_clr_i is dropped silently.
  assign w_push_req = rxts_valid_i & r_ts_pending & w_keep & ~q_clr_i;
  assign w_orphan   = rxts_valid_i & ~r_ts_pending & ~q_clr_i;
  assign w_pop      = q_rd_i & ~w_empty & ~q_clr_i;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf      = w_push_req & w_full & ~w_pop;

  // The record pairs with the time latched before this cycle's trig, if any.
  assign w_rec = '{
    ts:       r_ts_latch,
    src:      rx_sourcePortIdentity_i,
    seq:      rx_seqId_i,
    msg_type: rx_messageType_i,
    sdo_id:   rx_majorSdoId_i
  };

  // NOTE: storage is deliberately left out of reset; the valid gate on the head outputs hides stale data.
  always_ff @(posedge rtc_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge rtc_clk or posedge rtc_rst) begin
    if (rtc_rst) begin
      r_ts_latch   <= '0;
      r_ts_pending <= 1'b0;
    end else begin
      if (rxts_trig_i) begin
        r_ts_latch <= rtc_time_i;
      end
      if (q_clr_i) begin
        r_ts_pending <= 1'b0;
      end else if (rxts_trig_i) begin
        r_ts_pending <= 1'b1;
      end else if (rxts_valid_i) begin
        r_ts_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge rtc_clk or posedge rtc_rst) begin
    if (rtc_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (q_clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge rtc_clk or posedge rtc_rst) begin
    if (rtc_rst) begin
      r_ovf_cnt    <= '0;
      r_orphan_cnt <= '0;
    end else if (q_clr_i) begin
      r_ovf_cnt    <= '0;
      r_orphan_cnt <= '0;
    end else begin
      if (w_ovf && (r_ovf_cnt != 8'hFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
      if (w_orphan && (r_orphan_cnt != 8'hFF)) begin
        r_orphan_cnt <= r_orphan_cnt + 8'd1;
      end
    end
  end

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];

  assign q_valid_o      = ~w_empty;
  assign int_rxts_o     = ~w_empty;
  assign q_ts_o         = w_head.ts       & {80{q_valid_o}};
  assign q_srcPortId_o  = w_head.src      & {80{q_valid_o}};
  assign q_seqId_o      = w_head.seq      & {16{q_valid_o}};
  assign q_msgType_o    = w_head.msg_type & {4{q_valid_o}};
  assign q_sdoId_o      = w_head.sdo_id   & {4{q_valid_o}};
  assign q_level_o      = r_wr_ptr - r_rd_ptr;
  assign q_ovf_cnt_o    = r_ovf_cnt;
  assign q_orphan_cnt_o = r_orphan_cnt;

endmodule

// File: tb/tb_rx_ts_queue.sv
// Self-checking bench for rx_ts_queue: expected records are queued at stimulus time and compared at pop.
module tb_rx_ts_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct packed {
    logic [79:0] ts;
    logic [79:0] src;
    logic [15:0] seq;
    logic [3:0]  mt;
    logic [3:0]  sdo;
  } rec_t;

  logic          rtc_clk = 1'b0;
  logic          rtc_rst;
  logic [79:0]   rtc_time_i;
  logic          rxts_trig_i;
  logic          rxts_valid_i;
  logic [79:0]   rx_sourcePortIdentity_i;
  logic [15:0]   rx_seqId_i;
  logic [3:0]    rx_messageType_i;
  logic [3:0]    rx_majorSdoId_i;
  logic          q_clr_i;
  logic          q_rd_i;
  logic          q_valid_o;
  logic [79:0]   q_ts_o;
  logic [79:0]   q_srcPortId_o;
  logic [15:0]   q_seqId_o;
  logic [3:0]    q_msgType_o;
  logic [3:0]    q_sdoId_o;
  logic [AW:0]   q_level_o;
  logic [7:0]    q_ovf_cnt_o;
  logic [7:0]    q_orphan_cnt_o;
  logic          int_rxts_o;

  rec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  rx_ts_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .rtc_clk                 (rtc_clk),
    .rtc_rst                 (rtc_rst),
    .rtc_time_i              (rtc_time_i),
    .rxts_trig_i             (rxts_trig_i),
    .rxts_valid_i            (rxts_valid_i),
    .rx_sourcePortIdentity_i (rx_sourcePortIdentity_i),
    .rx_seqId_i              (rx_seqId_i),
    .rx_messageType_i        (rx_messageType_i),
    .rx_majorSdoId_i         (rx_majorSdoId_i),
    .q_clr_i                 (q_clr_i),
    .q_rd_i                  (q_rd_i),
    .q_valid_o               (q_valid_o),
    .q_ts_o                  (q_ts_o),
    .q_srcPortId_o           (q_srcPortId_o),
    .q_seqId_o               (q_seqId_o),
    .q_msgType_o             (q_msgType_o),
    .q_sdoId_o               (q_sdoId_o),
    .q_level_o               (q_level_o),
    .q_ovf_cnt_o             (q_ovf_cnt_o),
    .q_orphan_cnt_o          (q_orphan_cnt_o),
    .int_rxts_o              (int_rxts_o)
  );

  always #5 rtc_clk = ~rtc_clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge rtc_clk);
    #1;
  endtask

  function automatic rec_t mk_rec(input logic [79:0] ts, input logic [15:0] seq, input logic [3:0] mt);
    rec_t r;
    r.ts  = ts;
    r.src = {seq, 64'h0123_4567_89AB_CDEF};
    r.seq = seq;
    r.mt  = mt;
    r.sdo = seq[3:0] ^ 4'h9;
    return r;
  endfunction

  task automatic set_fields(input logic [15:0] seq, input logic [3:0] mt);
    rec_t r;
    r = mk_rec('0, seq, mt);
    rx_sourcePortIdentity_i = r.src;
    rx_seqId_i              = r.seq;
    rx_messageType_i        = r.mt;
    rx_majorSdoId_i         = r.sdo;
  endtask

  task automatic do_trig(input logic [79:0] t);
    rtc_time_i  = t;
    rxts_trig_i = 1'b1;
    tick();
    rxts_trig_i = 1'b0;
  endtask

  task automatic do_valid(input logic [15:0] seq, input logic [3:0] mt);
    set_fields(seq, mt);
    rxts_valid_i = 1'b1;
    tick();
    rxts_valid_i = 1'b0;
  endtask

  function automatic logic [79:0] tval(input int n);
    return {48'(n + 32'h100), 32'(n * 7 + 3)};
  endfunction

  // Scoreboard drain: compare the show-ahead head with the oldest expected record, then pop it.
  task automatic pop_and_compare(input string name);
    rec_t exp_r;
    rec_t got;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, DUT q_valid_o=%0b", name, q_valid_o);
    end else begin
      exp_r = sb.pop_front();
      got   = {q_ts_o, q_srcPortId_o, q_seqId_o, q_msgType_o, q_sdoId_o};
      if (q_valid_o !== 1'b1 || got !== exp_r) begin
        n_err++;
        $display("FAIL %s: valid=%0b head=%h expected=%h", name, q_valid_o, got, exp_r);
      end
    end
    q_rd_i = 1'b1;
    tick();
    q_rd_i = 1'b0;
  endtask

  task automatic test_reset();
    rtc_rst = 1'b1;
    #12;
    n_vec++;
    if ({q_valid_o, int_rxts_o, q_level_o, q_ovf_cnt_o, q_orphan_cnt_o, q_ts_o, q_seqId_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%0b int=%0b level=%0d ovf=%0d orph=%0d ts=%h seq=%h",
               q_valid_o, int_rxts_o, q_level_o, q_ovf_cnt_o, q_orphan_cnt_o, q_ts_o, q_seqId_o);
    end
    @(negedge rtc_clk);
    rtc_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [79:0] t;
    t = 80'h0000_0000_0001_0000_0064;
    do_trig(t);
    tick();
    tick();
    n_vec++;
    if (q_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_pre_valid: q_valid_o=%0b expected 0", q_valid_o);
    end
    do_valid(16'h0005, 4'h0);
    sb.push_back(mk_rec(t, 16'h0005, 4'h0));
    n_vec++;
    if (q_ts_o !== t || q_seqId_o !== 16'h0005 || int_rxts_o !== 1'b1 || q_level_o !== 3'd1) begin
      n_err++;
      $display("FAIL single_visible: ts=%h seq=%h int=%0b level=%0d", q_ts_o, q_seqId_o, int_rxts_o, q_level_o);
    end
    pop_and_compare("single_pop");
    n_vec++;
    if (q_valid_o !== 1'b0 || int_rxts_o !== 1'b0 || q_ts_o !== '0) begin
      n_err++;
      $display("FAIL single_empty_after_pop: valid=%0b int=%0b ts=%h expected 0", q_valid_o, int_rxts_o, q_ts_o);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 5; i++) begin
      do_trig(tval(i));
      do_valid(16'(i), 4'h1);
      if (i <= DEPTH) sb.push_back(mk_rec(tval(i), 16'(i), 4'h1));
    end
    n_vec++;
    if (q_level_o !== 3'd4 || q_ovf_cnt_o !== 8'd1) begin
      n_err++;
      $display("FAIL fill_overflow: level=%0d ovf=%0d expected 4 and 1", q_level_o, q_ovf_cnt_o);
    end
  endtask

  task automatic test_full_push_pop();
    rec_t exp_r;
    rec_t got;
    do_trig(tval(6));
    exp_r = sb.pop_front();
    got   = {q_ts_o, q_srcPortId_o, q_seqId_o, q_msgType_o, q_sdoId_o};
    n_vec++;
    if (got !== exp_r) begin
      n_err++;
      $display("FAIL full_pp_head: head=%h expected=%h", got, exp_r);
    end
    set_fields(16'd6, 4'h2);
    rxts_valid_i = 1'b1;
    q_rd_i       = 1'b1;
    tick();
    rxts_valid_i = 1'b0;
    q_rd_i       = 1'b0;
    sb.push_back(mk_rec(tval(6), 16'd6, 4'h2));
    n_vec++;
    if (q_level_o !== 3'd4 || q_ovf_cnt_o !== 8'd1) begin
      n_err++;
      $display("FAIL full_pp_level: level=%0d ovf=%0d expected 4 and 1", q_level_o, q_ovf_cnt_o);
    end
    while (sb.size() > 0) pop_and_compare("full_pp_drain");
    n_vec++;
    if (q_level_o !== 3'd0 || q_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL full_pp_empty: level=%0d valid=%0b expected 0", q_level_o, q_valid_o);
    end
  endtask

  task automatic test_orphan_double_trig();
    do_valid(16'h0010, 4'h0);
    n_vec++;
    if (q_orphan_cnt_o !== 8'd1 || q_level_o !== 3'd0) begin
      n_err++;
      $display("FAIL orphan: orph=%0d level=%0d expected 1 and 0", q_orphan_cnt_o, q_level_o);
    end
    do_trig(tval(20));
    do_trig(tval(21));
    do_valid(16'h0011, 4'h3);
    sb.push_back(mk_rec(tval(21), 16'h0011, 4'h3));
    pop_and_compare("double_trig_last_wins");
    // An empty-queue read must not disturb the pointers.
    q_rd_i = 1'b1;
    tick();
    q_rd_i = 1'b0;
    n_vec++;
    if (q_level_o !== 3'd0 || q_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rd_while_empty: level=%0d valid=%0b expected 0", q_level_o, q_valid_o);
    end
  endtask

  task automatic test_same_cycle_trig_valid();
    do_trig(tval(30));
    set_fields(16'h0020, 4'h0);
    rtc_time_i   = tval(31);
    rxts_trig_i  = 1'b1;
    rxts_valid_i = 1'b1;
    tick();
    rxts_trig_i  = 1'b0;
    rxts_valid_i = 1'b0;
    sb.push_back(mk_rec(tval(30), 16'h0020, 4'h0));
    do_valid(16'h0021, 4'h1);
    sb.push_back(mk_rec(tval(31), 16'h0021, 4'h1));
    n_vec++;
    if (q_level_o !== 3'd2 || q_orphan_cnt_o !== 8'd1) begin
      n_err++;
      $display("FAIL same_cycle_level: level=%0d orph=%0d expected 2 and 1", q_level_o, q_orphan_cnt_o);
    end
    pop_and_compare("same_cycle_first");
    pop_and_compare("same_cycle_second");
    // With nothing pending, a combined trig+valid is an orphan but the trig still latches.
    set_fields(16'h0022, 4'h0);
    rtc_time_i   = tval(32);
    rxts_trig_i  = 1'b1;
    rxts_valid_i = 1'b1;
    tick();
    rxts_trig_i  = 1'b0;
    rxts_valid_i = 1'b0;
    do_valid(16'h0023, 4'h2);
    sb.push_back(mk_rec(tval(32), 16'h0023, 4'h2));
    n_vec++;
    if (q_orphan_cnt_o !== 8'd2 || q_level_o !== 3'd1) begin
      n_err++;
      $display("FAIL same_cycle_orphan: orph=%0d level=%0d expected 2 and 1", q_orphan_cnt_o, q_level_o);
    end
    pop_and_compare("same_cycle_orphan_latch");
  endtask

  task automatic test_filter();
    logic [AW:0] exp_level;
    do_trig(tval(40));
    do_valid(16'h0030, 4'hB);
`ifdef RX_TSQ_EVENT_FILTER_EN
    exp_level = 3'd0;
`else
    exp_level = 3'd1;
    sb.push_back(mk_rec(tval(40), 16'h0030, 4'hB));
`endif
    n_vec++;
    if (q_level_o !== exp_level || q_orphan_cnt_o !== 8'd2 || q_ovf_cnt_o !== 8'd1) begin
      n_err++;
      $display("FAIL filter_general: level=%0d orph=%0d ovf=%0d expected %0d, 2, 1",
               q_level_o, q_orphan_cnt_o, q_ovf_cnt_o, exp_level);
    end
    do_trig(tval(41));
    do_valid(16'h0031, 4'h1);
    sb.push_back(mk_rec(tval(41), 16'h0031, 4'h1));
    while (sb.size() > 0) pop_and_compare("filter_drain");
  endtask

  task automatic test_clear();
    for (int i = 50; i < 53; i++) begin
      do_trig(tval(i));
      do_valid(16'(i), 4'h0);
    end
    n_vec++;
    if (q_level_o !== 3'd3) begin
      n_err++;
      $display("FAIL clear_prefill: level=%0d expected 3", q_level_o);
    end
    do_trig(tval(53));
    set_fields(16'd53, 4'h0);
    rxts_valid_i = 1'b1;
    q_clr_i      = 1'b1;
    tick();
    rxts_valid_i = 1'b0;
    q_clr_i      = 1'b0;
    n_vec++;
    if (q_level_o !== 3'd0 || q_ovf_cnt_o !== 8'd0 || q_orphan_cnt_o !== 8'd0 || q_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL clear: level=%0d ovf=%0d orph=%0d valid=%0b expected all 0",
               q_level_o, q_ovf_cnt_o, q_orphan_cnt_o, q_valid_o);
    end
    do_valid(16'd54, 4'h0);
    n_vec++;
    if (q_orphan_cnt_o !== 8'd1 || q_level_o !== 3'd0) begin
      n_err++;
      $display("FAIL clear_pending: orph=%0d level=%0d expected 1 and 0", q_orphan_cnt_o, q_level_o);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < DEPTH + 260; i++) begin
      do_trig(tval(i));
      do_valid(16'(i), 4'h0);
    end
    for (int i = 0; i < 260; i++) do_valid(16'hFFFF, 4'h0);
    n_vec++;
    if (q_ovf_cnt_o !== 8'd255 || q_orphan_cnt_o !== 8'd255 || q_level_o !== 3'd4) begin
      n_err++;
      $display("FAIL saturation: ovf=%0d orph=%0d level=%0d expected 255, 255, 4",
               q_ovf_cnt_o, q_orphan_cnt_o, q_level_o);
    end
  endtask

  task automatic test_async_reset();
    do_trig(tval(70));
    #2;
    rtc_rst = 1'b1;
    #1;
    n_vec++;
    if ({q_valid_o, int_rxts_o, q_level_o, q_ovf_cnt_o, q_orphan_cnt_o, q_seqId_o} !== '0) begin
      n_err++;
      $display("FAIL async_reset: valid=%0b int=%0b level=%0d ovf=%0d orph=%0d",
               q_valid_o, int_rxts_o, q_level_o, q_ovf_cnt_o, q_orphan_cnt_o);
    end
    @(negedge rtc_clk);
    rtc_rst = 1'b0;
    tick();
    do_valid(16'd71, 4'h0);
    n_vec++;
    if (q_orphan_cnt_o !== 8'd1 || q_level_o !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset_pending: orph=%0d level=%0d expected 1 and 0", q_orphan_cnt_o, q_level_o);
    end
    sb.delete();
  endtask

  initial begin
    rtc_rst                 = 1'b0;
    rtc_time_i              = '0;
    rxts_trig_i             = 1'b0;
    rxts_valid_i            = 1'b0;
    rx_sourcePortIdentity_i = '0;
    rx_seqId_i              = '0;
    rx_messageType_i        = '0;
    rx_majorSdoId_i         = '0;
    q_clr_i                 = 1'b0;
    q_rd_i                  = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_orphan_double_trig();
    test_same_cycle_trig_valid();
    test_filter();
    test_clear();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
